nice_bcast_scheduler: RTL and testbench

- RTL scheduler for a one-to-many broadcast channel, the hardware counterpart of the broadcaster facility in the components package.
- Round-robin arbitrates N_REQ requesters and latches the winner's word.
- Presents the word to N_SUB subscribers and holds it until every enabled subscriber has accepted it exactly once; only then does it take the next request.
- Sits between producer agents and a subscriber fan-out, and serialises all broadcasts through a single shared channel.

---
 rtl/nice_bcast_pkg.sv | 43 ++++
 rtl/nice_rr_arbiter.sv | 33 +++
 rtl/nice_bcast_scheduler.sv | 133 +++++++++++++
 tb/tb_nice_bcast_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nice_bcast_pkg.sv
// rtl/nice_bcast_pkg.sv - shared types and round-robin pick helper for the broadcast scheduler
package nice_bcast_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BCAST = 1'b1
  } state_e;

  // Widest requester set the pick helper can scan, and the index width it returns.
  localparam int unsigned RR_MAX_N = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Width of a source-index tag for n requesters (never below 1 bit).
  function automatic int unsigned src_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First set bit of valid[n-1:0], scanning upward from ptr and wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] valid,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int unsigned         n);
    rr_pick_t            r;
    logic [RR_IDX_W:0]   k;
    r = '0;
    for (int unsigned off = 0; off < RR_MAX_N; off++) begin
      k = {1'b0, ptr} + (RR_IDX_W+1)'(off);
      if (32'(k) >= n) begin
        k = k - (RR_IDX_W+1)'(n);
      end
      if ((off < n) && !r.found && valid[k[RR_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = k[RR_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nice_rr_arbiter.sv
// rtl/nice_rr_arbiter.sv - combinational round-robin arbiter; pointer is held by the caller
module nice_rr_arbiter
  import nice_bcast_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = src_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  rr_pick_t pick;

  // Scan the request vector starting at the caller's pointer.
  always_comb begin
    pick = rr_pick(RR_MAX_N'(req), RR_IDX_W'(ptr), N);
  end

  assign found = pick.found;
  assign idx   = IDX_W'(pick.idx);

  // Expand the winning index into a one-hot grant; zero when nobody requests.
  always_comb begin
    grant = '0;
    if (found) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/nice_bcast_scheduler.sv
// rtl/nice_bcast_scheduler.sv - serialises round-robin requests onto a one-to-many broadcast channel
module nice_bcast_scheduler
  import nice_bcast_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned N_SUB  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SRC_W  = src_width(N_REQ),
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_SUB-1:0]        sub_en,
  output logic [N_SUB-1:0]        sub_valid,
  input  logic [N_SUB-1:0]        sub_ready,
  output logic [DATA_W-1:0]       sub_data,
  output logic [SRC_W-1:0]        sub_src,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        drop_cnt
);

  state_e              state_q, state_d;
  logic [N_SUB-1:0]    pending_q, pending_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                done_q, done_d;

  logic [N_REQ-1:0]    win_grant;
  logic [SRC_W-1:0]    win_idx;
  logic                win_found;
  logic [DATA_W-1:0]   win_data;
  logic [N_SUB-1:0]    still_pending;

  nice_rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (SRC_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (win_grant),
    .idx   (win_idx),
    .found (win_found)
  );

  // Select the winning requester's word from the packed request bus.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == SRC_W'(i)) begin
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Subscribers still owing an accept after this cycle's handshakes.
  assign still_pending = pending_q & ~sub_ready;

  // Next-state and output decode: capture in IDLE, drain the pending mask in BCAST.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    rr_ptr_d   = rr_ptr_q;
    data_d     = data_q;
    src_d      = src_q;
    drop_cnt_d = drop_cnt_q;
    done_d     = 1'b0;
    req_ready  = '0;
    sub_valid  = '0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready = win_grant;
          data_d    = win_data;
          src_d     = win_idx;
          pending_d = sub_en;
          rr_ptr_d  = (win_idx == SRC_W'(N_REQ-1)) ? '0 : win_idx + SRC_W'(1);
          if (sub_en != '0) begin
            state_d = BCAST;
          end else begin
            // Nobody to deliver to: retire immediately and count it.
            done_d = 1'b1;
            if (drop_cnt_q != '1) begin
              drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      BCAST: begin
        busy      = 1'b1;
        sub_valid = pending_q;
        pending_d = still_pending;
        if (still_pending == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      data_q     <= '0;
      src_q      <= '0;
      drop_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      data_q     <= data_d;
      src_q      <= src_d;
      drop_cnt_q <= drop_cnt_d;
      done_q     <= done_d;
    end
  end

  assign sub_data = data_q;
  assign sub_src  = src_q;
  assign drop_cnt = drop_cnt_q;
  assign done     = done_q;

endmodule

// File: tb/tb_nice_bcast_scheduler.sv
// tb/tb_nice_bcast_scheduler.sv - directed and randomized checks of the broadcast scheduler
module tb_nice_bcast_scheduler;

  localparam int N_REQ    = 4;
  localparam int N_SUB    = 4;
  localparam int DATA_W   = 32;
  localparam int SRC_W    = 2;
  localparam int CNT_W    = 2;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_SUB-1:0]        sub_en;
  logic [N_SUB-1:0]        sub_valid;
  logic [N_SUB-1:0]        sub_ready;
  logic [DATA_W-1:0]       sub_data;
  logic [SRC_W-1:0]        sub_src;
  logic                    busy;
  logic                    done;
  logic [CNT_W-1:0]        drop_cnt;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model: broadcast in flight?, outstanding subscribers, pointer, latched word.
  bit               m_busy;
  bit               m_done;
  logic [N_SUB-1:0] m_pending;
  int               m_ptr;
  int               m_src;
  int               m_drop;
  logic [31:0]      m_data;

  always #5 clk = ~clk;

  nice_bcast_scheduler #(
    .N_REQ  (N_REQ),
    .N_SUB  (N_SUB),
    .DATA_W (DATA_W),
    .SRC_W  (SRC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .sub_en    (sub_en),
    .sub_valid (sub_valid),
    .sub_ready (sub_ready),
    .sub_data  (sub_data),
    .sub_src   (sub_src),
    .busy      (busy),
    .done      (done),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (m_ptr + k) % N_REQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_pending = '0; m_ptr = 0; m_src = 0; m_drop = 0; m_data = '0;
  endtask

  task automatic model_compare();
    logic [N_REQ-1:0] e_rr;
    logic [N_SUB-1:0] e_sv;
    int w;
    e_rr = '0;
    e_sv = '0;
    if (m_busy) e_sv = m_pending;
    else begin
      w = winner();
      if (w >= 0) e_rr[w] = 1'b1;
    end
    chk("m_req_ready", req_ready, e_rr);
    chk("m_sub_valid", sub_valid, e_sv);
    chk("m_busy", busy, m_busy);
    chk("m_done", done, m_done);
    chk("m_sub_data", sub_data, m_data);
    chk("m_sub_src", sub_src, m_src);
    chk("m_drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic model_step();
    int w;
    if (rst) model_reset();
    else if (!m_busy) begin
      m_done = 0;
      w = winner();
      if (w >= 0) begin
        m_data = req_data[w*DATA_W +: DATA_W];
        m_src  = w;
        m_ptr  = (w + 1) % N_REQ;
        if (sub_en == 0) begin
          m_done = 1;
          if (m_drop < DROP_MAX) m_drop++;
        end else begin
          m_busy    = 1;
          m_pending = sub_en;
        end
      end
    end else begin
      m_pending = m_pending & ~sub_ready;
      m_done    = (m_pending == 0);
      if (m_done) m_busy = 0;
    end
  endtask

  // Sample on the falling edge, then advance the model and the DUT by one cycle.
  task automatic mid();
    @(negedge clk);
    model_compare();
  endtask

  task automatic fin();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    mid();
    fin();
  endtask

  int          t2_src[5]  = '{0, 1, 2, 3, 0};
  logic [3:0]  t2_gnt[4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0]  t3_rdy[5]  = '{4'b0001, 4'b0001, 4'b1000, 4'b0000, 4'b0010};
  logic [3:0]  t3_sv[5]   = '{4'b1011, 4'b1010, 4'b1010, 4'b0010, 4'b0010};

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; sub_en = '0; sub_ready = '0;
    @(posedge clk); #1;
    model_reset();

    // Reset state
    mid();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_drop", drop_cnt, 0); chk("rst_sub_valid", sub_valid, 0);
    fin();
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = 32'h1000_0000 + i;

    // Reset while broadcasting with pending 0110
    req_valid = 4'b0010; sub_en = 4'b0110;
    mid(); chk("t1_grant", req_ready, 4'b0010); fin();
    req_valid = '0;
    mid(); chk("t1_pending", sub_valid, 4'b0110); chk("t1_busy_pre", busy, 1); fin();
    rst = 1'b1;
    cyc();
    rst = 1'b0; req_valid = 4'b1111; sub_en = 4'b1111; sub_ready = 4'b1111;
    mid();
    chk("t1_busy", busy, 0); chk("t1_sub_valid", sub_valid, 0);
    chk("t1_done", done, 0); chk("t1_drop", drop_cnt, 0);
    chk("t1_ptr_reset", req_ready, 4'b0001);
    fin();

    // Fairness with everything always ready
    for (int c = 0; c < 9; c++) begin
      mid();
      chk("t2_busy", busy, (c % 2 == 0));
      if (c % 2 == 0) chk("t2_src", sub_src, t2_src[c/2]);
      else            chk("t2_grant", req_ready, t2_gnt[c/2]);
      fin();
    end

    // Staggered accept of a 1011 mask
    req_valid = '0; sub_ready = '0;
    cyc();
    req_valid = 4'b0100; req_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF; sub_en = 4'b1011;
    mid(); chk("t3_grant", req_ready, 4'b0100); fin();
    req_valid = '0; sub_en = '0;
    for (int k = 0; k < 5; k++) begin
      sub_ready = t3_rdy[k];
      mid();
      chk("t3_sub_valid", sub_valid, t3_sv[k]);
      chk("t3_sub_data", sub_data, 32'hDEADBEEF);
      chk("t3_no_done", done, 0);
      fin();
    end

    // Pointer wrap from 3 and skip of idle requesters
    sub_ready = 4'b1111; sub_en = 4'b1111; req_valid = 4'b0101;
    mid();
    chk("t3_done", done, 1); chk("t3_idle_valid", sub_valid, 0);
    chk("t3_hold_data", sub_data, 32'hDEADBEEF);
    chk("t6_wrap", req_ready, 4'b0001);
    fin();
    mid(); chk("t6_src0", sub_src, 0); fin();
    mid(); chk("t6_skip", req_ready, 4'b0100); fin();
    req_valid = '0;
    mid(); chk("t6_src2", sub_src, 2); fin();
    cyc();

    // Drops and counter saturation
    req_valid = 4'b0010; sub_en = '0;
    mid(); chk("t4_grant", req_ready, 4'b0010); chk("t4_idle", busy, 0); fin();
    req_valid = '0;
    mid(); chk("t4_done", done, 1); chk("t4_busy", busy, 0); chk("t4_drop1", drop_cnt, 1); fin();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) cyc();
    req_valid = '0;
    mid(); chk("t4_sat", drop_cnt, 3); chk("t4_done_last", done, 1); fin();
    mid(); chk("t4_done_clear", done, 0); fin();

    // Mask frozen at capture
    req_valid = 4'b1000; sub_en = 4'b0001; sub_ready = '0;
    cyc();
    req_valid = '0; sub_en = 4'b1111;
    mid(); chk("t5_mask", sub_valid, 4'b0001); fin();
    sub_ready = 4'b1110;
    mid(); chk("t5_mask_ign", sub_valid, 4'b0001); chk("t5_busy", busy, 1); fin();
    sub_ready = 4'b0001;
    mid(); chk("t5_last", sub_valid, 4'b0001); fin();
    sub_ready = '0;
    mid(); chk("t5_done", done, 1); chk("t5_idle", busy, 0); fin();

    // Randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req_valid = N_REQ'($urandom);
      sub_en    = ($urandom_range(0, 4) == 0) ? '0 : N_SUB'($urandom);
      sub_ready = N_SUB'($urandom);
      for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = $urandom;
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
